// File: rtl/ws2812_rx_pkg.sv
// Shared timing constants, state encoding and small helpers for the WS2812 receiver.
package ws2812_rx_pkg;

   // Pulse-width classification limits, in sys_clk cycles (50 MHz).
   localparam logic [6:0]  T_MIN    = 7'd8;     // shorter high pulse is a glitch
   localparam logic [6:0]  T_THR    = 7'd30;    // high >= T_THR decodes as 1
   localparam logic [6:0]  T_MAX    = 7'd60;    // longer high pulse is illegal
   localparam logic [11:0] RST_CYC  = 12'd2500; // low time that latches a frame
   localparam logic [6:0]  MAX_PIX  = 7'd64;    // pixels per frame
   localparam logic [4:0]  PIX_BITS = 5'd24;    // bits per pixel

   typedef enum logic [1:0] {
      WAIT_RST = 2'd0,
      IDLE     = 2'd1,
      HIGH     = 2'd2,
      LOW      = 2'd3
   } state_t;

   function automatic logic [6:0] sat_inc7(input logic [6:0] v);
      return (v == 7'h7f) ? v : v + 7'd1;
   endfunction

   function automatic logic [11:0] sat_inc12(input logic [11:0] v);
      return (v == 12'hfff) ? v : v + 12'd1;
   endfunction

endpackage

// File: rtl/ws2812_edge_sync.sv
// Two-flop synchronizer for the asynchronous din pin plus a third flop for
// single-cycle rise/fall pulses on the synchronized level.
module ws2812_edge_sync (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic din,
   output logic din_s,
   output logic rise,
   output logic fall
);

   logic [2:0] sync_q;

   // Shift the pin through the synchronizer and the edge-detect stage.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) sync_q <= '0;
      else            sync_q <= {sync_q[1:0], din};
   end

   assign din_s = sync_q[1];
   assign rise  = sync_q[1] & ~sync_q[2];
   assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 single-wire stream decoder: measures high pulses, classifies bits,
// assembles 24-bit pixels MSB-first and reports frame ends on the latch gap.
// pix_valid, frame_done and err are single-cycle pulses with no back-pressure;
// pix_data/pix_idx/frame_len hold their last value between pulses.
module ws2812_rx
   import ws2812_rx_pkg::*;
(
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        din,
   output logic        pix_valid,
   output logic [23:0] pix_data,
   output logic [5:0]  pix_idx,
   output logic        frame_done,
   output logic [6:0]  frame_len,
   output logic        err,
   output state_t      dbg_state
);

   logic din_s, rise, fall;

   state_t      state, state_d;
   logic [6:0]  hi_cnt, hi_cnt_d;
   logic [11:0] low_cnt, low_cnt_d;
   logic [4:0]  bit_cnt, bit_cnt_d;
   logic [6:0]  pix_cnt, pix_cnt_d;
   logic [23:0] shreg, shreg_d;
   logic        pix_valid_d, frame_done_d, err_d, abort;
   logic [23:0] pix_data_d;
   logic [5:0]  pix_idx_d;
   logic [6:0]  frame_len_d;

   ws2812_edge_sync u_sync (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .din       (din),
      .din_s     (din_s),
      .rise      (rise),
      .fall      (fall)
   );

   assign dbg_state = state;

   // Register FSM state, counters, shifter and output pulses.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= WAIT_RST;
         hi_cnt     <= '0;
         low_cnt    <= '0;
         bit_cnt    <= '0;
         pix_cnt    <= '0;
         shreg      <= '0;
         pix_valid  <= 1'b0;
         pix_data   <= '0;
         pix_idx    <= '0;
         frame_done <= 1'b0;
         frame_len  <= '0;
         err        <= 1'b0;
      end else begin
         state      <= state_d;
         hi_cnt     <= hi_cnt_d;
         low_cnt    <= low_cnt_d;
         bit_cnt    <= bit_cnt_d;
         pix_cnt    <= pix_cnt_d;
         shreg      <= shreg_d;
         pix_valid  <= pix_valid_d;
         pix_data   <= pix_data_d;
         pix_idx    <= pix_idx_d;
         frame_done <= frame_done_d;
         frame_len  <= frame_len_d;
         err        <= err_d;
      end
   end

   // Next-state, counter and output decode.
   always_comb begin
      state_d      = state;
      hi_cnt_d     = hi_cnt;
      low_cnt_d    = low_cnt;
      bit_cnt_d    = bit_cnt;
      pix_cnt_d    = pix_cnt;
      shreg_d      = shreg;
      pix_valid_d  = 1'b0;
      pix_data_d   = pix_data;
      pix_idx_d    = pix_idx;
      frame_done_d = 1'b0;
      frame_len_d  = frame_len;
      err_d        = 1'b0;
      abort        = 1'b0;

      // A full pixel in the shifter is released one cycle after its last bit.
      if (bit_cnt == PIX_BITS) begin
         bit_cnt_d = '0;
         if (pix_cnt == MAX_PIX) begin
            abort = 1'b1;
         end else begin
            pix_valid_d = 1'b1;
            pix_data_d  = shreg;
            pix_idx_d   = pix_cnt[5:0];
            pix_cnt_d   = pix_cnt + 7'd1;
         end
      end

      case (state)
         WAIT_RST: begin
            if (din_s)                       low_cnt_d = '0;
            else if (low_cnt == RST_CYC - 12'd1) begin
               state_d   = IDLE;
               low_cnt_d = '0;
            end else                         low_cnt_d = sat_inc12(low_cnt);
         end
         IDLE: begin
            if (rise) begin
               state_d  = HIGH;
               hi_cnt_d = 7'd1;
            end
         end
         HIGH: begin
            if (fall) begin
               if (hi_cnt < T_MIN || hi_cnt > T_MAX) begin
                  abort = 1'b1;
               end else begin
                  shreg_d   = {shreg[22:0], (hi_cnt >= T_THR)};
                  bit_cnt_d = bit_cnt + 5'd1;
                  low_cnt_d = 12'd1;
                  state_d   = LOW;
               end
            end else if (hi_cnt >= T_MAX) begin
               // Still high after T_MAX cycles: cannot become a legal bit.
               abort = 1'b1;
            end else begin
               hi_cnt_d = sat_inc7(hi_cnt);
            end
         end
         LOW: begin
            if (rise) begin
               state_d  = HIGH;
               hi_cnt_d = 7'd1;
            end else if (low_cnt == RST_CYC - 12'd1) begin
               // LOW is only reached after a legal bit, so a frame always ends here.
               frame_done_d = 1'b1;
               frame_len_d  = pix_cnt;
               err_d        = (bit_cnt != 5'd0);
               pix_cnt_d    = '0;
               bit_cnt_d    = '0;
               low_cnt_d    = '0;
               state_d      = IDLE;
            end else begin
               low_cnt_d = sat_inc12(low_cnt);
            end
         end
         default: state_d = WAIT_RST;
      endcase

      // Any violation drops the frame and waits for a clean latch gap.
      if (abort) begin
         err_d       = 1'b1;
         pix_valid_d = 1'b0;
         pix_data_d  = pix_data;
         pix_idx_d   = pix_idx;
         state_d     = WAIT_RST;
         low_cnt_d   = '0;
         bit_cnt_d   = '0;
         pix_cnt_d   = '0;
      end
   end

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: drives din pulse trains and scores pixels,
// frame ends and error pulses against hand-computed expectations.
module tb_ws2812_rx;
   import ws2812_rx_pkg::*;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        din = 1'b0;
   logic        pix_valid;
   logic [23:0] pix_data;
   logic [5:0]  pix_idx;
   logic        frame_done;
   logic [6:0]  frame_len;
   logic        err;
   state_t      dbg_state;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int last_fall_cyc = 0;
   int err_cnt = 0;
   int err_base = 0;

   logic [29:0] exp_q[$];   // {idx, data}
   logic [7:0]  exp_fq[$];  // {err, frame_len}
   logic [29:0] e_pix;
   logic [7:0]  e_frm;
   logic [23:0] d5;

   ws2812_rx dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .din        (din),
      .pix_valid  (pix_valid),
      .pix_data   (pix_data),
      .pix_idx    (pix_idx),
      .frame_done (frame_done),
      .frame_len  (frame_len),
      .err        (err),
      .dbg_state  (dbg_state)
   );

   // Clock and cycle counter.
   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Driver tasks: entered and left on a falling clock edge.
   task automatic pulse(input int hi, input int lo);
      din = 1'b1;
      repeat (hi) @(negedge sys_clk);
      din = 1'b0;
      last_fall_cyc = cyc;
      repeat (lo) @(negedge sys_clk);
   endtask

   task automatic gap(input int n);
      din = 1'b0;
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic send_pixel(input logic [23:0] d, input int t0, input int t1, input int lo);
      for (int i = 23; i >= 0; i--) pulse(d[i] ? t1 : t0, lo);
   endtask

   task automatic exp_pix(input logic [5:0] idx, input logic [23:0] d);
      exp_q.push_back({idx, d});
   endtask

   task automatic exp_frame(input logic e, input logic [6:0] len);
      exp_fq.push_back({e, len});
   endtask

   task automatic end_test(input string tag, input int exp_errs);
      check({tag, "_pix_left"}, exp_q.size(), 0);
      check({tag, "_frm_left"}, exp_fq.size(), 0);
      check({tag, "_err_cnt"}, err_cnt - err_base, exp_errs);
      exp_q.delete();
      exp_fq.delete();
      err_base = err_cnt;
   endtask

   // Scoreboard: every output pulse is matched against the expected queues.
   always @(negedge sys_clk) begin
      if (sys_rst_n) begin
         if (err) err_cnt++;
         if (pix_valid) begin
            check("pix_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               e_pix = exp_q.pop_front();
               check("pix_data", pix_data, e_pix[23:0]);
               check("pix_idx", pix_idx, e_pix[29:24]);
               check("pix_latency", cyc - last_fall_cyc, 4);
            end
         end
         if (frame_done) begin
            check("frm_expected", exp_fq.size() != 0, 1'b1);
            if (exp_fq.size() != 0) begin
               e_frm = exp_fq.pop_front();
               check("frm_err_len", {err, frame_len}, e_frm);
            end
         end
         if (pix_valid || frame_done) check("pv_fd_excl", pix_valid & frame_done, 1'b0);
      end
   end

   initial begin
      // Reset state.
      repeat (3) @(negedge sys_clk);
      check("rst_pix_valid", pix_valid, 0);
      check("rst_pix_data", pix_data, 0);
      check("rst_pix_idx", pix_idx, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_frame_len", frame_len, 0);
      check("rst_err", err, 0);
      check("rst_state", dbg_state, WAIT_RST);
      sys_rst_n = 1'b1;
      gap(2600);
      check("idle_after_gap", dbg_state, IDLE);
      end_test("t0", 0);

      // 1: three primary-colour pixels then a latch gap.
      exp_pix(6'd0, 24'hFF0000);
      exp_pix(6'd1, 24'h00FF00);
      exp_pix(6'd2, 24'h0000FF);
      exp_frame(1'b0, 7'd3);
      send_pixel(24'hFF0000, 20, 40, 20);
      send_pixel(24'h00FF00, 20, 40, 20);
      send_pixel(24'h0000FF, 20, 40, 20);
      gap(2600);
      end_test("t1", 0);

      // 2: threshold 29/30 and legal extremes 8/60.
      exp_pix(6'd0, 24'hA5C35A);
      exp_pix(6'd1, 24'h0F0F33);
      exp_frame(1'b0, 7'd2);
      send_pixel(24'hA5C35A, 29, 30, 12);
      send_pixel(24'h0F0F33, 8, 60, 12);
      gap(2600);
      end_test("t2", 0);

      // 3: 5-clk glitch mid-pixel; traffic ignored until a full gap.
      for (int i = 0; i < 10; i++) pulse(20, 12);
      pulse(5, 12);
      check("t3_state_glitch", dbg_state, WAIT_RST);
      send_pixel(24'h5A5A5A, 20, 40, 12);
      gap(2600);
      exp_pix(6'd0, 24'h123456);
      exp_frame(1'b0, 7'd1);
      send_pixel(24'h123456, 20, 40, 12);
      gap(2600);
      end_test("t3", 1);

      // 4a: 12 bits then gap -> frame_done with len 0 and err together.
      exp_frame(1'b1, 7'd0);
      for (int i = 0; i < 12; i++) pulse(40, 12);
      gap(2600);
      end_test("t4a", 1);

      // 4b: 1 pixel + 12 bits -> len 1 and err.
      exp_pix(6'd0, 24'hC0FFEE);
      exp_frame(1'b1, 7'd1);
      send_pixel(24'hC0FFEE, 20, 40, 12);
      for (int i = 0; i < 12; i++) pulse(20, 12);
      gap(2600);
      end_test("t4b", 1);

      // 5: 65 pixels back-to-back -> 64 reported, then overflow error.
      for (int i = 0; i < 65; i++) begin
         d5 = 24'(i);
         if (i < 64) exp_pix(6'(i), d5);
         send_pixel(d5, 9, 30, 4);
      end
      check("t5_state_ovf", dbg_state, WAIT_RST);
      gap(2600);
      end_test("t5_ovf", 1);
      check("t5_idle", dbg_state, IDLE);
      pulse(61, 4);
      check("t5_state_long", dbg_state, WAIT_RST);
      gap(2600);
      end_test("t5_long", 1);

      // 6: reset in the middle of pixel 10.
      for (int i = 0; i < 9; i++) begin
         exp_pix(6'(i), 24'(i + 1));
         send_pixel(24'(i + 1), 9, 30, 4);
      end
      for (int i = 0; i < 10; i++) pulse(9, 4);
      din = 1'b1;
      repeat (5) @(negedge sys_clk);
      sys_rst_n = 1'b0;
      repeat (2) @(negedge sys_clk);
      check("t6_rst_pix_valid", pix_valid, 0);
      check("t6_rst_pix_data", pix_data, 0);
      check("t6_rst_pix_idx", pix_idx, 0);
      check("t6_rst_frame_len", frame_len, 0);
      check("t6_rst_err", err, 0);
      check("t6_rst_state", dbg_state, WAIT_RST);
      sys_rst_n = 1'b1;
      repeat (5) @(negedge sys_clk);
      din = 1'b0;
      repeat (4) @(negedge sys_clk);
      for (int i = 0; i < 14; i++) pulse(30, 4);
      send_pixel(24'h777777, 9, 30, 4);
      gap(2600);
      exp_pix(6'd0, 24'hABCDEF);
      exp_frame(1'b0, 7'd1);
      send_pixel(24'hABCDEF, 20, 40, 12);
      gap(2600);
      end_test("t6", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
